// File: rtl/naive_bus_arbiter2.sv
// naive_bus_arbiter2: two-master to one-slave naive bus arbiter with fixed priority and ageing.
// Requests are forwarded combinationally; ownership is held until the slave grants.
module naive_bus_arbiter2 #(
   parameter int PRIO_M0  = 1,
   parameter int MAX_WAIT = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        m0_rd_req,
   input  logic [31:0] m0_rd_addr,
   output logic        m0_rd_gnt,
   output logic [31:0] m0_rd_data,
   input  logic        m0_wr_req,
   input  logic [31:0] m0_wr_addr,
   input  logic [31:0] m0_wr_data,
   input  logic [3:0]  m0_wr_be,
   output logic        m0_wr_gnt,
   input  logic        m1_rd_req,
   input  logic [31:0] m1_rd_addr,
   output logic        m1_rd_gnt,
   output logic [31:0] m1_rd_data,
   input  logic        m1_wr_req,
   input  logic [31:0] m1_wr_addr,
   input  logic [31:0] m1_wr_data,
   input  logic [3:0]  m1_wr_be,
   output logic        m1_wr_gnt,
   output logic        s_rd_req,
   output logic [31:0] s_rd_addr,
   input  logic        s_rd_gnt,
   input  logic [31:0] s_rd_data,
   output logic        s_wr_req,
   output logic [31:0] s_wr_addr,
   output logic [31:0] s_wr_data,
   output logic [3:0]  s_wr_be,
   input  logic        s_wr_gnt
);
   localparam int WCW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
   localparam logic LP = (PRIO_M0 != 0) ? 1'b1 : 1'b0;
   localparam logic [WCW-1:0] WMAX = WCW'(MAX_WAIT);

   typedef enum logic [1:0] {IDLE = 2'd0, OWN0 = 2'd1, OWN1 = 2'd2} state_t;

   state_t         r_state, w_next;
   logic           r_rd_vld, r_rd_sel;
   logic [WCW-1:0] r_wait_cnt;
   logic           w_req0, w_req1, w_age, w_arb, w_vld, w_own;
   logic           w_lp_req, w_lp_gnt, w_lp_own;

   assign w_req0 = m0_rd_req | m0_wr_req;
   assign w_req1 = m1_rd_req | m1_wr_req;
   assign w_age  = (MAX_WAIT != 0) && (r_wait_cnt == WMAX);
   assign w_arb  = (w_req0 & w_req1) ? (w_age ? LP : ~LP) : w_req1;
   // Forwarding is suppressed while reset is asserted so nothing leaks to the slave.
   assign w_vld  = rst_n & ((r_state != IDLE) | w_req0 | w_req1);
   assign w_own  = (r_state == OWN1) | ((r_state == IDLE) & w_arb);

   always_comb begin
      w_next = IDLE;
      if (w_vld && !(s_rd_gnt || s_wr_gnt) && (w_own ? w_req1 : w_req0))
         w_next = w_own ? OWN1 : OWN0;
   end

   assign s_rd_req  = w_vld & (w_own ? m1_rd_req : m0_rd_req);
   assign s_wr_req  = w_vld & (w_own ? m1_wr_req : m0_wr_req);
   assign s_rd_addr = w_vld ? (w_own ? m1_rd_addr : m0_rd_addr) : 32'h0;
   assign s_wr_addr = w_vld ? (w_own ? m1_wr_addr : m0_wr_addr) : 32'h0;
   assign s_wr_data = w_vld ? (w_own ? m1_wr_data : m0_wr_data) : 32'h0;
   assign s_wr_be   = w_vld ? (w_own ? m1_wr_be : m0_wr_be) : 4'h0;

   assign m0_rd_gnt = s_rd_gnt & w_vld & ~w_own & m0_rd_req;
   assign m0_wr_gnt = s_wr_gnt & w_vld & ~w_own & m0_wr_req;
   assign m1_rd_gnt = s_rd_gnt & w_vld & w_own & m1_rd_req;
   assign m1_wr_gnt = s_wr_gnt & w_vld & w_own & m1_wr_req;

   assign m0_rd_data = (r_rd_vld & ~r_rd_sel) ? s_rd_data : 32'h0;
   assign m1_rd_data = (r_rd_vld & r_rd_sel) ? s_rd_data : 32'h0;

   assign w_lp_req = LP ? w_req1 : w_req0;
   assign w_lp_gnt = LP ? (m1_rd_gnt | m1_wr_gnt) : (m0_rd_gnt | m0_wr_gnt);
   assign w_lp_own = w_vld & (w_own == LP);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= IDLE;
         r_rd_vld   <= 1'b0;
         r_rd_sel   <= 1'b0;
         r_wait_cnt <= '0;
      end else begin
         r_state    <= w_next;
         r_rd_vld   <= s_rd_gnt;
         r_rd_sel   <= s_rd_gnt ? w_own : r_rd_sel;
         r_wait_cnt <= (!w_lp_req || w_lp_gnt) ? '0 :
                       (!w_lp_own && r_wait_cnt != WMAX) ? r_wait_cnt + 1'b1 : r_wait_cnt;
      end
   end
endmodule

// File: tb/tb_naive_bus_arbiter2.sv
// tb_naive_bus_arbiter2: directed checks of arbitration, ownership hold, ageing, read return and reset.
module tb_naive_bus_arbiter2;
   logic        clk = 1'b0, rst_n = 1'b0;
   logic        m0_rd_req, m0_wr_req, m1_rd_req, m1_wr_req;
   logic [31:0] m0_rd_addr, m0_wr_addr, m0_wr_data, m1_rd_addr, m1_wr_addr, m1_wr_data;
   logic [3:0]  m0_wr_be, m1_wr_be;
   logic        m0_rd_gnt, m0_wr_gnt, m1_rd_gnt, m1_wr_gnt;
   logic [31:0] m0_rd_data, m1_rd_data;
   logic        s_rd_req, s_wr_req, s_rd_gnt, s_wr_gnt;
   logic [31:0] s_rd_addr, s_wr_addr, s_wr_data, s_rd_data;
   logic [3:0]  s_wr_be;
   int          checks = 0, errors = 0;

   naive_bus_arbiter2 #(.PRIO_M0(1), .MAX_WAIT(2)) dut (
      .clk(clk), .rst_n(rst_n),
      .m0_rd_req(m0_rd_req), .m0_rd_addr(m0_rd_addr), .m0_rd_gnt(m0_rd_gnt), .m0_rd_data(m0_rd_data),
      .m0_wr_req(m0_wr_req), .m0_wr_addr(m0_wr_addr), .m0_wr_data(m0_wr_data), .m0_wr_be(m0_wr_be),
      .m0_wr_gnt(m0_wr_gnt),
      .m1_rd_req(m1_rd_req), .m1_rd_addr(m1_rd_addr), .m1_rd_gnt(m1_rd_gnt), .m1_rd_data(m1_rd_data),
      .m1_wr_req(m1_wr_req), .m1_wr_addr(m1_wr_addr), .m1_wr_data(m1_wr_data), .m1_wr_be(m1_wr_be),
      .m1_wr_gnt(m1_wr_gnt),
      .s_rd_req(s_rd_req), .s_rd_addr(s_rd_addr), .s_rd_gnt(s_rd_gnt), .s_rd_data(s_rd_data),
      .s_wr_req(s_wr_req), .s_wr_addr(s_wr_addr), .s_wr_data(s_wr_data), .s_wr_be(s_wr_be),
      .s_wr_gnt(s_wr_gnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clr();
      m0_rd_req = 0; m0_wr_req = 0; m1_rd_req = 0; m1_wr_req = 0;
      m0_rd_addr = 0; m0_wr_addr = 0; m0_wr_data = 0; m0_wr_be = 0;
      m1_rd_addr = 0; m1_wr_addr = 0; m1_wr_data = 0; m1_wr_be = 0;
      s_rd_gnt = 0; s_wr_gnt = 0; s_rd_data = 0;
   endtask

   initial begin
      clr();
      tick(); tick();
      chk("rst_state", 32'(dut.r_state), 32'd0);
      chk("rst_wait", 32'(dut.r_wait_cnt), 32'd0);
      chk("rst_srdreq", 32'(s_rd_req), 32'd0);
      chk("rst_m0rdata", m0_rd_data, 32'h0);
      rst_n = 1'b1;
      tick();
      // single master read
      m1_rd_req = 1; m1_rd_addr = 32'h100; s_rd_gnt = 1;
      #2;
      chk("single_srdreq", 32'(s_rd_req), 32'd1);
      chk("single_saddr", s_rd_addr, 32'h100);
      chk("single_m1gnt", 32'(m1_rd_gnt), 32'd1);
      chk("single_m0gnt", 32'(m0_rd_gnt), 32'd0);
      tick();
      clr(); s_rd_data = 32'hDEADBEEF;
      #2;
      chk("single_m1data", m1_rd_data, 32'hDEADBEEF);
      chk("single_m0data", m0_rd_data, 32'h0);
      tick();
      #2;
      chk("single_data_gone", m1_rd_data, 32'h0);
      tick();
      // contention: m0 write vs m1 read
      clr();
      m0_wr_req = 1; m0_wr_addr = 32'h2000; m0_wr_data = 32'hCAFE; m0_wr_be = 4'hF;
      m1_rd_req = 1; m1_rd_addr = 32'h0; s_rd_gnt = 1; s_wr_gnt = 1;
      #2;
      chk("cont_m0wgnt", 32'(m0_wr_gnt), 32'd1);
      chk("cont_m1gnt0", 32'(m1_rd_gnt), 32'd0);
      chk("cont_swaddr", s_wr_addr, 32'h2000);
      chk("cont_swdata", s_wr_data, 32'hCAFE);
      chk("cont_swbe", 32'(s_wr_be), 32'hF);
      chk("cont_srdreq0", 32'(s_rd_req), 32'd0);
      tick();
      m0_wr_req = 0;
      #2;
      chk("cont_m1gnt1", 32'(m1_rd_gnt), 32'd1);
      chk("cont_m0wgnt1", 32'(m0_wr_gnt), 32'd0);
      chk("cont_wait1", 32'(dut.r_wait_cnt), 32'd1);
      tick();
      #2;
      chk("cont_wait_clr", 32'(dut.r_wait_cnt), 32'd0);
      // ownership hold
      clr(); m1_rd_req = 1; m1_rd_addr = 32'h300;
      #2;
      chk("hold_c0_addr", s_rd_addr, 32'h300);
      chk("hold_c0_gnt", 32'(m1_rd_gnt), 32'd0);
      tick();
      m0_rd_req = 1; m0_rd_addr = 32'h400;
      #2;
      chk("hold_c1_addr", s_rd_addr, 32'h300);
      chk("hold_c1_state", 32'(dut.r_state), 32'd2);
      tick();
      #2;
      chk("hold_c2_addr", s_rd_addr, 32'h300);
      tick();
      s_rd_gnt = 1;
      #2;
      chk("hold_m1gnt", 32'(m1_rd_gnt), 32'd1);
      chk("hold_m0gnt0", 32'(m0_rd_gnt), 32'd0);
      tick();
      m1_rd_req = 0;
      #2;
      chk("hold_m0addr", s_rd_addr, 32'h400);
      chk("hold_m0gnt", 32'(m0_rd_gnt), 32'd1);
      tick();
      // ageing with MAX_WAIT = 2
      clr();
      m0_rd_req = 1; m0_rd_addr = 32'hA0; m1_rd_req = 1; m1_rd_addr = 32'hB0; s_rd_gnt = 1;
      #2;
      chk("age_a0_m0", 32'(m0_rd_gnt), 32'd1);
      chk("age_a0_m1", 32'(m1_rd_gnt), 32'd0);
      tick();
      #2;
      chk("age_a1_m0", 32'(m0_rd_gnt), 32'd1);
      chk("age_a1_wait", 32'(dut.r_wait_cnt), 32'd1);
      tick();
      #2;
      chk("age_a2_wait", 32'(dut.r_wait_cnt), 32'd2);
      chk("age_a2_m1", 32'(m1_rd_gnt), 32'd1);
      chk("age_a2_m0", 32'(m0_rd_gnt), 32'd0);
      chk("age_a2_addr", s_rd_addr, 32'hB0);
      tick();
      #2;
      chk("age_wait_clr", 32'(dut.r_wait_cnt), 32'd0);
      chk("age_a3_m0", 32'(m0_rd_gnt), 32'd1);
      tick();
      // read interleave
      clr();
      tick();
      m0_rd_req = 1; m0_rd_addr = 32'h10; s_rd_gnt = 1;
      #2;
      chk("il_m0gnt", 32'(m0_rd_gnt), 32'd1);
      tick();
      m0_rd_req = 0; m1_rd_req = 1; m1_rd_addr = 32'h20; s_rd_data = 32'h11;
      #2;
      chk("il_m1gnt", 32'(m1_rd_gnt), 32'd1);
      chk("il_m0data", m0_rd_data, 32'h11);
      chk("il_m1data0", m1_rd_data, 32'h0);
      tick();
      m1_rd_req = 0; s_rd_gnt = 0; s_rd_data = 32'h22;
      #2;
      chk("il_m1data", m1_rd_data, 32'h22);
      chk("il_m0data0", m0_rd_data, 32'h0);
      tick();
      // reset while m1 waits for a grant
      clr(); m1_rd_req = 1; m1_rd_addr = 32'h500;
      tick();
      #2;
      chk("rm_state_own1", 32'(dut.r_state), 32'd2);
      rst_n = 0; s_rd_gnt = 1;
      #1;
      chk("rm_state", 32'(dut.r_state), 32'd0);
      chk("rm_m1gnt", 32'(m1_rd_gnt), 32'd0);
      chk("rm_srdreq", 32'(s_rd_req), 32'd0);
      tick();
      chk("rm_m1data", m1_rd_data, 32'h0);
      clr();
      rst_n = 1;
      tick();
      chk("rm_state_after", 32'(dut.r_state), 32'd0);
      m0_rd_req = 1; m0_rd_addr = 32'h600;
      #2;
      chk("rm_fwd_req", 32'(s_rd_req), 32'd1);
      chk("rm_fwd_addr", s_rd_addr, 32'h600);
      tick();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
